// File: rtl/decoder_pkg.sv
// Shared types for the sequential one-hot decoder: request modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b01,
        PULSE = 2'b10,
        SCAN  = 2'b11
    } state_t;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational binary-to-one-hot decode with range flag; zero vector when out of range.
module decoder_onehot #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               inRange
);

    // Extra bit lets NUM_OUT == 2**SEL_W compare without overflow.
    assign inRange = ({1'b0, sel} < (SEL_W+1)'(NUM_OUT));
    assign onehot  = inRange ? (NUM_OUT'(1) << sel) : '0;

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready request intake and hold, timed pulse
// and auto-scan output modes.
//
// state | meaning
// IDLE  | outputs cleared, accepting requests
// HOLD  | static one-hot output, accepting replacement requests
// PULSE | one-hot output for PULSE_LEN cycles, requests blocked
// SCAN  | rotating one-hot output, SCAN_PERIOD cycles per position, until stop
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W       = 3,
    parameter int NUM_OUT     = 8,
    parameter int PULSE_LEN   = 4,
    parameter int SCAN_PERIOD = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   selIn,
    input  logic [1:0]         mode,
    input  logic               selValid,
    output logic               selReady,
    input  logic               stop,
    output logic [NUM_OUT-1:0] dataOut,
    output logic               busy,
    output logic               errOut
);

    localparam int PCNT_W = $clog2(PULSE_LEN + 1);
    localparam int SCNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_LEN - 1);
    localparam logic [SCNT_W-1:0] SCAN_LOAD  = SCNT_W'(SCAN_PERIOD - 1);
    localparam logic [SEL_W-1:0]  LAST_IDX   = SEL_W'(NUM_OUT - 1);

    state_t               state_q, state_d;
    logic [NUM_OUT-1:0]   data_q, data_d;
    logic                 err_q, err_d;
    logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [SEL_W-1:0]     idx_next;
    logic [NUM_OUT-1:0]   req_vec, scan_vec;
    logic                 req_ok, scan_ok;
    logic                 accept;
    mode_t                req_mode;

    assign req_mode = mode_t'(mode);
    assign selReady = ((state_q == IDLE) || (state_q == HOLD)) && !stop;
    assign accept   = selValid && selReady;
    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    decoder_onehot #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_req_dec (
        .sel     (selIn),
        .onehot  (req_vec),
        .inRange (req_ok)
    );

    decoder_onehot #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_scan_dec (
        .sel     (idx_next),
        .onehot  (scan_vec),
        .inRange (scan_ok)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = 1'b0;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;

        if (stop) begin
            state_d = IDLE;
            data_d  = '0;
            pcnt_d  = '0;
            scnt_d  = '0;
            idx_d   = '0;
        end else if (accept) begin
            pcnt_d = '0;
            scnt_d = '0;
            idx_d  = '0;
            if (!req_ok || (req_mode == MODE_RSVD)) begin
                err_d   = 1'b1;
                data_d  = '0;
                state_d = IDLE;
            end else begin
                data_d = req_vec;
                case (req_mode)
                    MODE_HOLD: begin
                        state_d = HOLD;
                    end
                    MODE_PULSE: begin
                        pcnt_d  = PULSE_LOAD;
                        state_d = PULSE;
                    end
                    default: begin
                        idx_d   = selIn;
                        scnt_d  = SCAN_LOAD;
                        state_d = SCAN;
                    end
                endcase
            end
        end else begin
            // Counters hold the cycles remaining after the current one.
            case (state_q)
                PULSE: begin
                    if (pcnt_q == '0) begin
                        data_d  = '0;
                        state_d = IDLE;
                    end else begin
                        pcnt_d = pcnt_q - 1'b1;
                    end
                end
                SCAN: begin
                    if (scnt_q == '0) begin
                        idx_d  = idx_next;
                        data_d = scan_ok ? scan_vec : '0;
                        scnt_d = SCAN_LOAD;
                    end else begin
                        scnt_d = scnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
            pcnt_q  <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
        end
    end

    assign dataOut = data_q;
    assign errOut  = err_q;
    assign busy    = (state_q == PULSE) || (state_q == SCAN);

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: default-parameter table plus a NUM_OUT=6 error/wrap sequence.
module tb_decoder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst, selValid, stop, selReady, busy, errOut;
    logic [2:0] selIn;
    logic [1:0] mode;
    logic [7:0] dataOut;

    // NUM_OUT = 6 instance
    logic       rst6, selValid6, stop6, selReady6, busy6, errOut6;
    logic [2:0] selIn6;
    logic [1:0] mode6;
    logic [5:0] dataOut6;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_seq dut (
        .clk      (clk),
        .rst      (rst),
        .selIn    (selIn),
        .mode     (mode),
        .selValid (selValid),
        .selReady (selReady),
        .stop     (stop),
        .dataOut  (dataOut),
        .busy     (busy),
        .errOut   (errOut)
    );

    decoder_seq #(.SEL_W(3), .NUM_OUT(6), .PULSE_LEN(4), .SCAN_PERIOD(2)) dut6 (
        .clk      (clk),
        .rst      (rst6),
        .selIn    (selIn6),
        .mode     (mode6),
        .selValid (selValid6),
        .selReady (selReady6),
        .stop     (stop6),
        .dataOut  (dataOut6),
        .busy     (busy6),
        .errOut   (errOut6)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] sel;
        logic [1:0] mode;
        logic       stop;
        logic [7:0] data;
        logic       busy;
        logic       rdy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    // Inputs are applied for the step; expectations are the outputs seen during that step.
    task automatic add(input logic r, input logic v, input logic [2:0] s, input logic [1:0] m,
                       input logic st, input logic [7:0] d, input logic b, input logic rd,
                       input logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.mode = m; t.stop = st;
        t.data = d; t.busy = b; t.rdy = rd; t.err = e;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int step, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive6(input logic r, input logic v, input logic [2:0] s,
                          input logic [1:0] m, input logic st);
        @(posedge clk);
        #1;
        rst6 = r; selValid6 = v; selIn6 = s; mode6 = m; stop6 = st;
        @(negedge clk);
    endtask

    task automatic chk6(input string name, input int step, input logic [5:0] d,
                        input logic b, input logic rd, input logic e);
        chk({name, " data"},  step, {2'b00, dataOut6}, {2'b00, d});
        chk({name, " busy"},  step, {7'd0, busy6},     {7'd0, b});
        chk({name, " ready"}, step, {7'd0, selReady6}, {7'd0, rd});
        chk({name, " err"},   step, {7'd0, errOut6},   {7'd0, e});
    endtask

    initial begin
        rst = 1'b1; selValid = 1'b1; selIn = 3'd5; mode = 2'b00; stop = 1'b0;
        rst6 = 1'b1; selValid6 = 1'b0; selIn6 = 3'd0; mode6 = 2'b00; stop6 = 1'b0;

        // reset with selValid held
        add(1, 1, 5, 0, 0, 8'h00, 0, 1, 0);
        add(1, 1, 5, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        // HOLD 5, ten cycles, then direct replace with 0
        add(0, 1, 5, 0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 8'h20, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h20, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h01, 0, 1, 0);
        // PULSE 3 with a HOLD 2 request held throughout
        add(0, 1, 3, 1, 0, 8'h01, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 2, 0, 0, 8'h08, 1, 0, 0);
        add(0, 1, 2, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h04, 0, 1, 0);
        // SCAN from 6 with wrap, then stop
        add(0, 1, 6, 2, 0, 8'h04, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h40, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h40, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h80, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h80, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h01, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h01, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h02, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        // stop and selValid together in IDLE
        add(0, 1, 1, 0, 1, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        // rst during SCAN from 7
        add(0, 1, 7, 2, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h80, 1, 0, 0);
        add(1, 0, 0, 0, 0, 8'h80, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        // reserved mode
        add(0, 1, 1, 3, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; selValid = vecs[i].vld; selIn = vecs[i].sel;
            mode = vecs[i].mode; stop = vecs[i].stop;
            @(negedge clk);
            chk("data",  i, dataOut,         vecs[i].data);
            chk("busy",  i, {7'd0, busy},     {7'd0, vecs[i].busy});
            chk("ready", i, {7'd0, selReady}, {7'd0, vecs[i].rdy});
            chk("err",   i, {7'd0, errOut},   {7'd0, vecs[i].err});
            chk("onehot0", i, {7'd0, $onehot0(dataOut)}, 8'd1);
        end

        // NUM_OUT = 6: out-of-range select, reserved mode from HOLD, scan wrap 5 -> 0
        drive6(0, 1, 7, 0, 0); chk6("e6 req",      0, 6'h00, 0, 1, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 range",    1, 6'h00, 0, 1, 1);
        drive6(0, 0, 0, 0, 0); chk6("e6 clear",    2, 6'h00, 0, 1, 0);
        drive6(0, 1, 5, 0, 0); chk6("e6 hreq",     3, 6'h00, 0, 1, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 hold",     4, 6'h20, 0, 1, 0);
        drive6(0, 1, 2, 3, 0); chk6("e6 rsvreq",   5, 6'h20, 0, 1, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 rsv",      6, 6'h00, 0, 1, 1);
        drive6(0, 0, 0, 0, 0); chk6("e6 rsvclr",   7, 6'h00, 0, 1, 0);
        drive6(0, 1, 5, 2, 0); chk6("e6 sreq",     8, 6'h00, 0, 1, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 scan5a",   9, 6'h20, 1, 0, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 scan5b",  10, 6'h20, 1, 0, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 scan0a",  11, 6'h01, 1, 0, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 scan0b",  12, 6'h01, 1, 0, 0);
        drive6(0, 0, 0, 0, 1); chk6("e6 scan1",   13, 6'h02, 1, 0, 0);
        drive6(0, 0, 0, 0, 0); chk6("e6 stopped", 14, 6'h00, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
